// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Encoding 11 behaves as a word, so only the upper bit matters.
  function automatic logic is_word(input size_t size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [1:0]   lane,
  input  size_t        size,
  input  logic         sign_ext,
  input  logic [n-1:0] old_word,
  input  logic [n-1:0] new_data,
  output logic [n-1:0] load_data,
  output logic [n-1:0] merged
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;
  logic [4:0]        byte_pos;
  logic [4:0]        half_pos;

  always_comb begin
    byte_pos  = {lane, 3'b000};
    half_pos  = {lane[1], 4'b0000};
    byte_lane = old_word[byte_pos +: BYTE_W];
    half_lane = old_word[half_pos +: HALF_W];

    case (size)
      SZ_BYTE: load_data = {{(n-BYTE_W){sign_ext & byte_lane[BYTE_W-1]}}, byte_lane};
      SZ_HALF: load_data = {{(n-HALF_W){sign_ext & half_lane[HALF_W-1]}}, half_lane};
      default: load_data = old_word;
    endcase

    merged = old_word;
    case (size)
      SZ_BYTE: merged[byte_pos +: BYTE_W] = new_data[BYTE_W-1:0];
      SZ_HALF: merged[half_pos +: HALF_W] = new_data[HALF_W-1:0];
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit in front of word-only dmem; LSU_MISALIGN_CHECK_EN enables misalignment errors
module lsu
  import lsu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n-1:0] resp_rdata,
  output logic         resp_error,
  output logic [n-1:0] dmem_addr,
  output logic         dmem_write_enable,
  output logic [n-1:0] dmem_writedata,
  input  logic [n-1:0] dmem_readdata
);

  state_t       state, next_state;
  logic         write_q, signed_q, error_q;
  size_t        size_q;
  logic [n-1:0] addr_q, wdata_q, merged_q, rdata_q;
  logic         misaligned;
  logic [n-1:0] load_data, merged;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  lsu_align #(.n(n)) u_align (
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .old_word  (dmem_readdata),
    .new_data  (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = misaligned ? RESP : ACCESS;
      ACCESS:  next_state = (write_q && !is_word(size_q)) ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      error_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q  <= req_write;
          signed_q <= req_signed;
          size_q   <= req_size;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          error_q  <= misaligned;
          rdata_q  <= '0;
        end
        ACCESS: begin
          if (!write_q)                rdata_q  <= load_data;
          else if (!is_word(size_q))   merged_q <= merged;
        end
        default: ;
      endcase
    end
  end

  // The write strobe follows state alone, so a reset mid-RMW kills it at once.
  always_comb begin
    req_ready         = (state == IDLE);
    resp_valid        = (state == RESP);
    resp_rdata        = rdata_q;
    resp_error        = error_q;
    dmem_addr         = {2'b00, addr_q[n-1:2]};
    dmem_write_enable = 1'b0;
    dmem_writedata    = '0;
    case (state)
      ACCESS: if (write_q && is_word(size_q)) begin
        dmem_write_enable = 1'b1;
        dmem_writedata    = wdata_q;
      end
      WRITE: begin
        dmem_write_enable = 1'b1;
        dmem_writedata    = merged_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed bench for lsu with a small word dmem model
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_addr, dmem_writedata, dmem_readdata;
  logic        dmem_write_enable;

  logic [31:0] mem [0:15];
  int          wr_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu #(.n(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .dmem_addr         (dmem_addr),
    .dmem_write_enable (dmem_write_enable),
    .dmem_writedata    (dmem_writedata),
    .dmem_readdata     (dmem_readdata)
  );

  assign dmem_readdata = mem[dmem_addr[3:0]];

  always @(posedge clk) begin
    if (dmem_write_enable === 1'b1) begin
      mem[dmem_addr[3:0]] <= dmem_writedata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_error;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000FFFF;
    mem[2] = 32'hDEADBEEF;
    wr_cnt = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", {31'b0, resp_error}, 32'd0);
    check("rst_we", {31'b0, dmem_write_enable}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_writedata, 32'h0);
    @(negedge clk) reset = 1'b0;

    // 1: word store then word load
    wr_cnt = 0;
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, lat, rd, er);
    check("sw_lat", lat, 32'd2);
    check("sw_rdata", rd, 32'h0);
    check("sw_mem", mem[0], 32'hFFFFFFFF);
    check("sw_writes", wr_cnt, 32'd1);
    wr_cnt = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, er);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hFFFFFFFF);
    check("lw_writes", wr_cnt, 32'd0);

    // 2: byte store via read-modify-write
    wr_cnt = 0;
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000A5, lat, rd, er);
    check("sb_lat", lat, 32'd3);
    check("sb_writes", wr_cnt, 32'd1);
    check("sb_mem", mem[1], 32'h0000A5FF);

    // 3: sub-word loads
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, rd, er);
    check("lb_s", rd, 32'hFFFFFFA5);
    check("lb_lat", lat, 32'd2);
    issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, rd, er);
    check("lbu", rd, 32'h000000A5);
    issue(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, lat, rd, er);
    check("lbu_lane0", rd, 32'h000000FF);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, lat, rd, er);
    check("lh_s_hi", rd, 32'h00000000);
    issue(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, lat, rd, er);
    check("lh_s_lo", rd, 32'hFFFFA5FF);
    issue(1'b0, 2'b11, 1'b1, 32'h4, 32'h0, lat, rd, er);
    check("size3_word", rd, 32'h0000A5FF);

    // 4: misaligned half store
    wr_cnt = 0;
    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h00001234, lat, rd, er);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_lat", lat, 32'd1);
    check("mis_error", {31'b0, er}, 32'd1);
    check("mis_rdata", rd, 32'h0);
    check("mis_writes", wr_cnt, 32'd0);
    check("mis_mem", mem[0], 32'hFFFFFFFF);
`else
    check("mis_lat", lat, 32'd3);
    check("mis_error", {31'b0, er}, 32'd0);
    check("mis_writes", wr_cnt, 32'd1);
    check("mis_mem", mem[0], 32'h1234FFFF);
`endif

    // 5: response backpressure with a second request waiting
    wr_cnt = 0;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h4; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_addr = 32'h8;
    @(posedge clk); #1;
    check("bp_valid0", {31'b0, resp_valid}, 32'd1);
    check("bp_rdata0", resp_rdata, 32'h0000A5FF);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'h0000A5FF);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_accept2", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("bp_valid2", {31'b0, resp_valid}, 32'd1);
    check("bp_rdata2", resp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("bp_writes", wr_cnt, 32'd0);

    // 6: reset during the WRITE phase of a byte store
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h9; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_we", {31'b0, dmem_write_enable}, 32'd1);
    check("rmw_merged", dmem_writedata, 32'hDEAD77EF);
    #1 reset = 1'b1;
    #1;
    check("abort_we", {31'b0, dmem_write_enable}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("abort_mem", mem[2], 32'hDEADBEEF);
    check("abort_writes", wr_cnt, 32'd0);
    @(negedge clk) reset = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, er);
    check("post_rst_load", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
